// File: rtl/btn_pkg.sv
// Shared definitions for the button event path: FSM encoding and cycle-count helpers.
package btn_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StHold   = 2'd1,
    StRepeat = 2'd2
  } btn_state_e;

  // Rounded cycle count for a duration, never less than one cycle.
  function automatic int unsigned cycles_from(real freq_hz, real secs);
    int c;
    c = $rtoi(freq_hz * secs + 0.5);
    if (c < 1) c = 1;
    return unsigned'(c);
  endfunction

  function automatic int cnt_width(int unsigned a, int unsigned b);
    int unsigned m;
    m = (a > b) ? a : b;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/btn_cycle_timer.sv
// Loadable up-counter with clear, enable and saturation at a programmable terminal value.
module btn_cycle_timer #(
  parameter int unsigned Width = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             load,
  input  logic [Width-1:0] load_val,
  input  logic             inc,
  input  logic [Width-1:0] limit,
  output logic             tc
);

  logic [Width-1:0] count_q, count_d;

  assign tc = (count_q == limit);

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (load) begin
      count_d = load_val;
    end else if (inc && !tc) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/btn_event_gen.sv
// Turns a debounced button level into press, release and typematic repeat pulses.
module btn_event_gen
  import btn_pkg::*;
#(
  parameter int unsigned CLKIN_FREQ    = 27000000,
  parameter real         HOLD_DELAY    = 0.5,
  parameter real         REPEAT_PERIOD = 0.1
) (
  input  logic clk,
  input  logic reset,
  input  logic debounceIn,
  input  logic repeatEn,
  output logic pressPulse,
  output logic releasePulse,
  output logic repeatPulse,
  output logic heldOut
);

  localparam int unsigned HoldCycles   = cycles_from(real'(CLKIN_FREQ), HOLD_DELAY);
  localparam int unsigned RepeatCycles = cycles_from(real'(CLKIN_FREQ), REPEAT_PERIOD);
  localparam int          CntW         = cnt_width(HoldCycles, RepeatCycles);
  localparam logic [CntW-1:0] HoldLast   = CntW'(HoldCycles - 1);
  localparam logic [CntW-1:0] RepeatLast = CntW'(RepeatCycles - 1);

  btn_state_e      state_q, state_d;
  logic            rise, fall;
  logic            press_d, release_d, repeat_d;
  logic            cnt_clr, cnt_inc, cnt_tc;
  logic [CntW-1:0] cnt_limit;

  // heldOut doubles as the previous-level register for edge detection.
  assign rise = debounceIn & ~heldOut;
  assign fall = ~debounceIn & heldOut;

  btn_cycle_timer #(
    .Width (CntW)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .clr      (cnt_clr),
    .load     (1'b0),
    .load_val ('0),
    .inc      (cnt_inc),
    .limit    (cnt_limit),
    .tc       (cnt_tc)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      heldOut      <= 1'b0;
      pressPulse   <= 1'b0;
      releasePulse <= 1'b0;
      repeatPulse  <= 1'b0;
    end else begin
      state_q      <= state_d;
      heldOut      <= debounceIn;
      pressPulse   <= press_d;
      releasePulse <= release_d;
      repeatPulse  <= repeat_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (fall) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle:   if (rise) state_d = StHold;
        StHold:   if (cnt_tc && repeatEn) state_d = StRepeat;
        StRepeat: state_d = StRepeat;
        default:  state_d = StIdle;
      endcase
    end
  end

  // Release takes priority over a coincident terminal count.
  always_comb begin
    press_d   = 1'b0;
    release_d = 1'b0;
    repeat_d  = 1'b0;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    cnt_limit = (state_q == StRepeat) ? RepeatLast : HoldLast;
    if (fall) begin
      release_d = 1'b1;
      cnt_clr   = 1'b1;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (rise) begin
            press_d = 1'b1;
            cnt_clr = 1'b1;
          end
        end
        StHold: begin
          if (!cnt_tc) begin
            cnt_inc = 1'b1;
          end else if (repeatEn) begin
            repeat_d = 1'b1;
            cnt_clr  = 1'b1;
          end
        end
        StRepeat: begin
          if (!repeatEn) begin
            cnt_clr = 1'b1;
          end else if (cnt_tc) begin
            repeat_d = 1'b1;
            cnt_clr  = 1'b1;
          end else begin
            cnt_inc = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_btn_event_gen.sv
// Scoreboard bench for btn_event_gen: expected pulses are queued by cycle and checked each cycle.
module tb_btn_event_gen;

  logic clk = 1'b0;
  logic reset;
  logic debounceIn;
  logic repeatEn;
  logic pressPulse, releasePulse, repeatPulse, heldOut;

  localparam logic [2:0] EvPress   = 3'b100;
  localparam logic [2:0] EvRelease = 3'b010;
  localparam logic [2:0] EvRepeat  = 3'b001;

  typedef struct {
    int         cyc;
    logic [2:0] ev;
  } sb_t;

  sb_t  sb[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  bit   mon_en = 1'b0;
  logic exp_held = 1'b0;

  btn_event_gen #(
    .CLKIN_FREQ    (10000000),
    .HOLD_DELAY    (1e-6),
    .REPEAT_PERIOD (5e-7)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .debounceIn   (debounceIn),
    .repeatEn     (repeatEn),
    .pressPulse   (pressPulse),
    .releasePulse (releasePulse),
    .repeatPulse  (repeatPulse),
    .heldOut      (heldOut)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or negedge reset) begin
    if (!reset) exp_held <= 1'b0;
    else        exp_held <= debounceIn;
  end

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push(input int c, input logic [2:0] ev);
    sb_t e;
    e.cyc = c;
    e.ev  = ev;
    sb.push_back(e);
  endtask

  // Each cycle: outputs must be exactly the queued event for this cycle, else quiet.
  always @(negedge clk) begin
    if (mon_en) begin
      logic [3:0] exp;
      int         hit;
      exp = {3'b000, exp_held};
      hit = -1;
      foreach (sb[i]) if (hit < 0 && sb[i].cyc == cyc) hit = i;
      if (hit >= 0) begin
        exp[3:1] = sb[hit].ev;
        sb.delete(hit);
      end
      check_eq($sformatf("cyc%0d", cyc),
               int'({pressPulse, releasePulse, repeatPulse, heldOut}), int'(exp));
    end
  end

  // Hold the button for n sampling edges. en_at: offset of the first edge sampling repeatEn=1
  // (0 = enabled throughout). from_reset: the press comes from releasing reset while held.
  task automatic hold_btn(input int n, input int en_at, input bit from_reset);
    int t0, first;
    t0 = cyc + 1;
    if (from_reset) reset = 1'b1;
    else            debounceIn = 1'b1;
    repeatEn = (en_at == 0);
    push(t0, EvPress);
    if (en_at <= n) begin
      first = (en_at > 10) ? en_at : 10;
      for (int k = first; k < n; k += 5) push(t0 + k, EvRepeat);
    end
    push(t0 + n, EvRelease);
    @(negedge clk);
    for (int i = 1; i <= n; i++) begin
      if (i == en_at) repeatEn = 1'b1;
      if (i == n) debounceIn = 1'b0;
      @(negedge clk);
    end
    repeatEn = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int t0;
    reset      = 1'b0;
    debounceIn = 1'b1;
    repeatEn   = 1'b1;
    @(negedge clk);
    mon_en = 1'b1;
    repeat (5) @(negedge clk);

    hold_btn(3, 0, 1'b1);    // press straight out of reset
    hold_btn(30, 0, 1'b0);   // release coincides with a repeat terminal count
    hold_btn(28, 0, 1'b0);
    hold_btn(36, 21, 1'b0);  // repeat enabled late, after HOLD saturated
    hold_btn(25, 100, 1'b0); // repeat never enabled
    hold_btn(1, 0, 1'b0);    // single-cycle glitch

    // Async reset while a repeat pulse is high.
    t0 = cyc + 1;
    debounceIn = 1'b1;
    repeatEn   = 1'b1;
    push(t0, EvPress);
    push(t0 + 10, EvRepeat);
    push(t0 + 15, EvRepeat);
    repeat (16) @(negedge clk);
    #1 reset = 1'b0;
    #1 check_eq("async_rst",
                int'({pressPulse, releasePulse, repeatPulse, heldOut}), 0);
    repeat (3) @(negedge clk);
    hold_btn(12, 0, 1'b1);

    mon_en = 1'b0;
    check_eq("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
